// File: rtl/siso_pkg.sv
// Shared definitions for the SISO decoder: LLR widths, rounding modes and
// symmetric saturation.
package siso_pkg;

    localparam int LLR_W    = 16;
    localparam int METRIC_W = 16;

    typedef enum logic {
        RoundHalfAway = 1'b0,
        RoundFloor    = 1'b1
    } round_mode_e;

    // Clamp to +/-(2^(w-1)-1); the most negative code is never produced.
    function automatic logic signed [31:0] sat_sym(input logic signed [31:0] value,
                                                   input int unsigned w);
        logic signed [31:0] lim;
        lim = (32'sd1 <<< (w - 1)) - 32'sd1;
        if (value > lim) begin
            return lim;
        end
        if (value < -lim) begin
            return -lim;
        end
        return value;
    endfunction

endpackage

// File: rtl/bm_fifo.sv
// Synchronous FIFO with registered storage: data pushed into an empty FIFO is
// visible on rdata the cycle after the push.
module bm_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = DEPTH[CW-1:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/branch_metric_unit.sv
// Max-log-MAP branch-metric generator: joins channel and apriori LLR streams
// and emits -rnd((a+s+/-p)/2) per lane through a two-stage pipeline.
module branch_metric_unit
    import siso_pkg::*;
#(
    parameter int W          = LLR_W,
    parameter int LANES      = 1,
    parameter int DEPTH      = 4,
    parameter int ROUND_MODE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sp_valid,
    output logic               sp_ready,
    input  logic [LANES*W-1:0] sys,
    input  logic [LANES*W-1:0] parity,
    input  logic               sp_last,
    input  logic               ap_valid,
    output logic               ap_ready,
    input  logic [LANES*W-1:0] apriori,
    output logic               bm_valid,
    input  logic               bm_ready,
    output logic [LANES*W-1:0] bm0,
    output logic [LANES*W-1:0] bm1,
    output logic               bm_last,
    input  logic               sat_clr,
    output logic               sat_sticky
);

    localparam int XW   = W + 2;
    localparam int LW   = LANES * W;
    localparam int SP_W = 2 * LW + 1;
    localparam round_mode_e MODE = round_mode_e'(ROUND_MODE[0]);
    localparam logic signed [XW:0] ONE = 1;

    logic            sp_full, sp_empty, ap_full, ap_empty;
    logic [SP_W-1:0] sp_wdata, sp_rdata;
    logic [LW-1:0]   ap_rdata;
    logic            fire, s1_adv, s2_take;

    logic                 s1_valid, s1_last;
    logic signed [XW-1:0] s1_sum [LANES];
    logic signed [XW-1:0] s1_dif [LANES];
    logic signed [XW-1:0] sum_d  [LANES];
    logic signed [XW-1:0] dif_d  [LANES];
    logic signed [XW-1:0] a_x, s_x, p_x;

    logic [LW-1:0]      bm0_d, bm1_d;
    logic signed [31:0] v0, v1, r0, r1;
    logic               sat_any;

    assign sp_ready = !sp_full && !rst;
    assign ap_ready = !ap_full && !rst;
    assign sp_wdata = {sp_last, parity, sys};

    bm_fifo #(
        .DATA_W (SP_W),
        .DEPTH  (DEPTH)
    ) u_sp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (sp_valid && sp_ready),
        .wdata (sp_wdata),
        .pop   (fire),
        .rdata (sp_rdata),
        .full  (sp_full),
        .empty (sp_empty)
    );

    bm_fifo #(
        .DATA_W (LW),
        .DEPTH  (DEPTH)
    ) u_ap_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ap_valid && ap_ready),
        .wdata (apriori),
        .pop   (fire),
        .rdata (ap_rdata),
        .full  (ap_full),
        .empty (ap_empty)
    );

    assign s2_take = bm_ready || !bm_valid;
    assign s1_adv  = !s1_valid || s2_take;
    // Both FIFOs pop together so channel and apriori beats never drift apart.
    assign fire    = !sp_empty && !ap_empty && s1_adv;

    function automatic logic signed [XW-1:0] neg_half(input logic signed [XW-1:0] x);
        logic signed [XW:0] xe;
        xe = {x[XW-1], x};
        if (MODE == RoundHalfAway && x[0]) begin
            xe = x[XW-1] ? xe - ONE : xe + ONE;
        end
        xe = xe >>> 1;
        return -xe[XW-1:0];
    endfunction

    always_comb begin
        a_x = '0;
        s_x = '0;
        p_x = '0;
        for (int k = 0; k < LANES; k++) begin
            a_x      = XW'(signed'(ap_rdata[k*W +: W]));
            s_x      = XW'(signed'(sp_rdata[k*W +: W]));
            p_x      = XW'(signed'(sp_rdata[LW + k*W +: W]));
            sum_d[k] = a_x + s_x + p_x;
            dif_d[k] = a_x + s_x - p_x;
        end
    end

    always_comb begin
        bm0_d   = '0;
        bm1_d   = '0;
        v0      = '0;
        v1      = '0;
        r0      = '0;
        r1      = '0;
        sat_any = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            v0 = 32'(neg_half(s1_sum[k]));
            v1 = 32'(neg_half(s1_dif[k]));
            r0 = sat_sym(v0, W);
            r1 = sat_sym(v1, W);
            bm0_d[k*W +: W] = r0[W-1:0];
            bm1_d[k*W +: W] = r1[W-1:0];
            if (r0 != v0 || r1 != v1) begin
                sat_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            bm_valid   <= 1'b0;
            bm0        <= '0;
            bm1        <= '0;
            bm_last    <= 1'b0;
            sat_sticky <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= fire;
                if (fire) begin
                    s1_last <= sp_rdata[SP_W-1];
                    s1_sum  <= sum_d;
                    s1_dif  <= dif_d;
                end
            end
            if (s2_take) begin
                bm_valid <= s1_valid;
                if (s1_valid) begin
                    bm0     <= bm0_d;
                    bm1     <= bm1_d;
                    bm_last <= s1_last;
                end
            end
            if (s2_take && s1_valid && sat_any) begin
                sat_sticky <= 1'b1;
            end else if (sat_clr) begin
                sat_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_branch_metric_unit.sv
// Directed bench: a 4-lane half-away instance and a 1-lane floor instance.
module tb_branch_metric_unit;

    localparam int W = 16;
    localparam int L = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         sp_valid, sp_ready, sp_last, ap_valid, ap_ready;
    logic         bm_valid, bm_ready, bm_last, sat_clr, sat_sticky;
    logic [L*W-1:0] sys, parity, apriori, bm0, bm1;

    logic         sp_valid1, sp_ready1, ap_valid1, ap_ready1, bm_valid1, bm_last1, sat_sticky1;
    logic [W-1:0] bm0_1, bm1_1;

    int n_vec = 0;
    int n_err = 0;

    branch_metric_unit #(.W(W), .LANES(L), .DEPTH(4), .ROUND_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .sp_valid(sp_valid), .sp_ready(sp_ready), .sys(sys), .parity(parity), .sp_last(sp_last),
        .ap_valid(ap_valid), .ap_ready(ap_ready), .apriori(apriori),
        .bm_valid(bm_valid), .bm_ready(bm_ready), .bm0(bm0), .bm1(bm1), .bm_last(bm_last),
        .sat_clr(sat_clr), .sat_sticky(sat_sticky)
    );

    branch_metric_unit #(.W(W), .LANES(1), .DEPTH(4), .ROUND_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .sp_valid(sp_valid1), .sp_ready(sp_ready1), .sys(sys[W-1:0]), .parity(parity[W-1:0]),
        .sp_last(sp_last),
        .ap_valid(ap_valid1), .ap_ready(ap_ready1), .apriori(apriori[W-1:0]),
        .bm_valid(bm_valid1), .bm_ready(bm_ready), .bm0(bm0_1), .bm1(bm1_1), .bm_last(bm_last1),
        .sat_clr(sat_clr), .sat_sticky(sat_sticky1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int gen(input int i, input int b, input int k, input int which);
        if (which == 0) return b * 1000 + i * 11 - k * 7 - 3000;
        if (which == 1) return 2000 - i * 123 + k * 19 * b;
        return ((i + k) % 2 == 1) ? -(i * 31 + k + b) : i * 29 + k * b;
    endfunction

    function automatic logic [63:0] pack(input int i, input int b, input int which);
        logic [63:0] v;
        int x;
        v = '0;
        for (int k = 0; k < L; k++) begin
            x = gen(i, b, k, which);
            v[k*16 +: 16] = x[15:0];
        end
        return v;
    endfunction

    // Reference: round half away from zero, negate, clamp symmetrically.
    function automatic logic [15:0] ref_bm(input int x);
        int h, m;
        h = (x >= 0) ? (x + 1) / 2 : -((1 - x) / 2);
        m = -h;
        if (m > 32767) m = 32767;
        if (m < -32767) m = -32767;
        return m[15:0];
    endfunction

    function automatic logic [63:0] exp_bm(input int i, input int b, input bit dif);
        logic [63:0] v;
        int x;
        for (int k = 0; k < L; k++) begin
            x = gen(i, b, k, 0) + gen(i, b, k, 1) + (dif ? -gen(i, b, k, 2) : gen(i, b, k, 2));
            v[k*16 +: 16] = ref_bm(x);
        end
        return v;
    endfunction

    task automatic drive_sp(input int i, input int b);
        sys     = pack(i, b, 1);
        parity  = pack(i, b, 2);
        sp_last = (i == 7);
    endtask

    task automatic drive_ap(input int i, input int b);
        apriori = pack(i, b, 0);
    endtask

    task automatic send_one(input logic [63:0] a, input logic [63:0] s, input logic [63:0] p,
                            input logic last);
        apriori = a; sys = s; parity = p; sp_last = last;
        sp_valid = 1; ap_valid = 1; sp_valid1 = 1; ap_valid1 = 1;
        @(negedge clk);
        sp_valid = 0; ap_valid = 0; sp_valid1 = 0; ap_valid1 = 0;
    endtask

    task automatic wait_bm(input string tag);
        int t;
        t = 0;
        while (!bm_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check(tag, 64'(bm_valid), 64'd1);
    endtask

    initial begin
        sp_valid = 0; ap_valid = 0; sp_valid1 = 0; ap_valid1 = 0; sp_last = 0;
        sys = '0; parity = '0; apriori = '0; bm_ready = 1; sat_clr = 0;

        repeat (2) @(negedge clk);
        check("rst_sp_ready", 64'(sp_ready), 64'd0);
        check("rst_ap_ready", 64'(ap_ready), 64'd0);
        rst = 0;
        @(negedge clk);
        check("post_rst_sp_ready", 64'(sp_ready), 64'd1);
        check("post_rst_ap_ready", 64'(ap_ready), 64'd1);
        check("post_rst_bm_valid", 64'(bm_valid), 64'd0);
        check("post_rst_bm0", bm0, 64'd0);
        check("post_rst_bm1", bm1, 64'd0);
        check("post_rst_bm_last", 64'(bm_last), 64'd0);
        check("post_rst_sticky", 64'(sat_sticky), 64'd0);

        // Lanes: (3,4,2) (-3,-4,2) (0,0,0) (1,0,0)
        send_one({16'sd1, 16'sd0, -16'sd3, 16'sd3}, {16'sd0, 16'sd0, -16'sd4, 16'sd4},
                 {16'sd0, 16'sd0, 16'sd2, 16'sd2}, 1'b0);
        wait_bm("v1_valid");
        check("v1_bm0", bm0, {-16'sd1, 16'sd0, 16'sd3, -16'sd5});
        check("v1_bm1", bm1, {-16'sd1, 16'sd0, 16'sd5, -16'sd3});
        check("v1_last", 64'(bm_last), 64'd0);
        check("v1_floor_valid", 64'(bm_valid1), 64'd1);
        check("v1_floor_bm0", 64'(bm0_1), 64'(16'hfffc));
        check("v1_floor_bm1", 64'(bm1_1), 64'(16'hfffe));
        @(negedge clk);
        check("v1_sticky", 64'(sat_sticky), 64'd0);

        // Lanes: (-3,-4,2) (max,max,max) (min,min,min) (100,-50,7)
        send_one({16'sd100, 16'h8000, 16'sd32767, -16'sd3},
                 {-16'sd50, 16'h8000, 16'sd32767, -16'sd4},
                 {16'sd7, 16'h8000, 16'sd32767, 16'sd2}, 1'b1);
        wait_bm("v2_valid");
        check("v2_bm0", bm0, {-16'sd29, 16'sd32767, -16'sd32767, 16'sd3});
        check("v2_bm1", bm1, {-16'sd22, 16'sd16384, -16'sd16384, 16'sd5});
        check("v2_last", 64'(bm_last), 64'd1);
        check("v2_sticky_set", 64'(sat_sticky), 64'd1);
        check("v2_floor_bm0", 64'(bm0_1), 64'(16'h0003));
        check("v2_floor_bm1", 64'(bm1_1), 64'(16'h0005));
        check("v2_floor_sticky", 64'(sat_sticky1), 64'd0);
        sat_clr = 1;
        @(negedge clk);
        sat_clr = 0;
        check("sticky_clr", 64'(sat_sticky), 64'd0);

        // Continuous 8-beat stream, full throughput.
        for (int t = 0; t < 11; t++) begin
            if (t == 1 || t == 2) check($sformatf("lat_t%0d", t), 64'(bm_valid), 64'd0);
            if (t >= 3) begin
                check($sformatf("cont%0d_valid", t - 3), 64'(bm_valid), 64'd1);
                check($sformatf("cont%0d_bm0", t - 3), bm0, exp_bm(t - 3, 1, 1'b0));
                check($sformatf("cont%0d_bm1", t - 3), bm1, exp_bm(t - 3, 1, 1'b1));
                check($sformatf("cont%0d_last", t - 3), 64'(bm_last), 64'(t - 3 == 7));
            end
            if (t < 8) begin
                drive_sp(t, 1); drive_ap(t, 1);
                sp_valid = 1; ap_valid = 1;
            end else begin
                sp_valid = 0; ap_valid = 0;
            end
            @(negedge clk);
        end
        check("cont_drain", 64'(bm_valid), 64'd0);

        // Apriori stalled, then both streams with random downstream backpressure.
        fork
            begin : sp_src
                int i, g;
                logic rdy;
                i = 0; g = 0;
                drive_sp(0, 2);
                sp_valid = 1;
                while (i < 8 && g < 300) begin
                    rdy = sp_ready;
                    @(negedge clk);
                    g++;
                    if (rdy) begin
                        i++;
                        if (i < 8) drive_sp(i, 2);
                        else sp_valid = 0;
                    end
                end
                sp_valid = 0;
            end
            begin : ap_src
                int i, g;
                logic rdy;
                i = 0; g = 0;
                repeat (6) @(negedge clk);
                check("sp_full_ready", 64'(sp_ready), 64'd0);
                drive_ap(0, 2);
                ap_valid = 1;
                while (i < 8 && g < 300) begin
                    rdy = ap_ready;
                    @(negedge clk);
                    g++;
                    if (rdy) begin
                        i++;
                        if (i < 8) drive_ap(i, 2);
                        else ap_valid = 0;
                    end
                end
                ap_valid = 0;
            end
            begin : sink
                int j, g;
                j = 0; g = 0;
                while (j < 8 && g < 400) begin
                    bm_ready = 1'($urandom_range(0, 1));
                    if (bm_valid && bm_ready) begin
                        check($sformatf("bp%0d_bm0", j), bm0, exp_bm(j, 2, 1'b0));
                        check($sformatf("bp%0d_bm1", j), bm1, exp_bm(j, 2, 1'b1));
                        check($sformatf("bp%0d_last", j), 64'(bm_last), 64'(j == 7));
                        j++;
                    end
                    @(negedge clk);
                    g++;
                end
                check("bp_count", 64'(j), 64'd8);
                bm_ready = 1;
            end
        join
        repeat (4) @(negedge clk);
        check("bp_no_dup", 64'(bm_valid), 64'd0);

        // Reset with FIFOs half-full and a saturated beat held in stage2.
        bm_ready = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                sys = {4{16'h7fff}}; parity = {4{16'h7fff}}; apriori = {4{16'h7fff}};
                sp_last = 0;
            end else begin
                drive_sp(i, 3); drive_ap(i, 3);
            end
            sp_valid = 1; ap_valid = 1;
            @(negedge clk);
        end
        sp_valid = 0; ap_valid = 0;
        check("pre_rst_valid", 64'(bm_valid), 64'd1);
        check("pre_rst_sticky", 64'(sat_sticky), 64'd1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("mid_rst_valid", 64'(bm_valid), 64'd0);
        check("mid_rst_sticky", 64'(sat_sticky), 64'd0);
        bm_ready = 1;
        send_one(pack(5, 3, 0), pack(5, 3, 1), pack(5, 3, 2), 1'b0);
        wait_bm("fresh_valid");
        check("fresh_bm0", bm0, exp_bm(5, 3, 1'b0));
        check("fresh_bm1", bm1, exp_bm(5, 3, 1'b1));
        begin
            int extra;
            extra = 0;
            repeat (6) begin
                @(negedge clk);
                if (bm_valid) extra++;
            end
            check("no_stale_beats", 64'(extra), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
